// File: rtl/channel_serializer_if.sv
// Handshake bundle for channel_serializer: parallel vector in, serial word stream out.
// master = upstream/downstream driver (testbench side), slave = the serializer.
interface channel_serializer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_CHANNEL = 16
);
  logic [DATA_WIDTH*IN_CHANNEL-1:0] i_data;
  logic                             i_valid;
  logic                             o_ready;
  logic [DATA_WIDTH-1:0]            o_data;
  logic                             o_valid;
  logic                             o_last;
  logic                             i_ready;

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_last
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_last
  );
endinterface

// File: rtl/channel_serializer.sv
// Parallel-to-serial channel serializer, LSB channel first, registered outputs.
// Define SERIALIZER_SKID_EN to add a one-vector hold register for gapless back-to-back vectors.
module channel_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_CHANNEL = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  channel_serializer_if.slave  bus
);
  localparam int CW = (IN_CHANNEL > 1) ? $clog2(IN_CHANNEL) : 1;
  localparam logic [CW-1:0] LAST = CW'(IN_CHANNEL - 1);

  typedef logic [IN_CHANNEL-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  vec_t                  vec_q, in_vec, src_vec;
  logic [CW-1:0]         cha_cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] word_nxt, o_data_q;
  logic                  o_valid_q, o_last_q, ready;
  logic                  accept, xfer, last_xfer, load_new, load_hold, load;

  assign in_vec    = bus.i_data;
  assign accept    = bus.i_valid && ready;
  assign xfer      = o_valid_q && bus.i_ready;
  assign last_xfer = xfer && (cha_cnt == LAST);
  assign load      = load_new || load_hold;
  assign cnt_nxt   = cha_cnt + 1'b1;

`ifdef SERIALIZER_SKID_EN
  vec_t hold_q;
  logic hold_vld, hold_wr;

  assign ready     = !hold_vld;
  // A vector arriving on the last-word edge bypasses the hold register.
  assign load_new  = accept && (state_q == IDLE || last_xfer);
  assign load_hold = last_xfer && hold_vld;
  assign hold_wr   = accept && (state_q == SHIFT) && !last_xfer;
  assign src_vec   = load_hold ? hold_q : in_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      hold_vld <= 1'b0;
    end else if (hold_wr) begin
      hold_q   <= in_vec;
      hold_vld <= 1'b1;
    end else if (load_hold) begin
      hold_vld <= 1'b0;
    end
  end
`else
  assign ready     = (state_q == IDLE);
  assign load_new  = accept;
  assign load_hold = 1'b0;
  assign src_vec   = in_vec;
`endif

  always_comb begin
    word_nxt = vec_q[0];
    for (int k = 1; k < IN_CHANNEL; k++)
      if (cnt_nxt == CW'(k)) word_nxt = vec_q[k];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_xfer && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= '0;
      cha_cnt   <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else if (load) begin
      vec_q     <= src_vec;
      cha_cnt   <= '0;
      o_data_q  <= src_vec[0];
      o_valid_q <= 1'b1;
      o_last_q  <= (LAST == '0);
    end else if (xfer) begin
      if (cha_cnt == LAST) begin
        // o_data deliberately holds the final word while idle
        cha_cnt   <= '0;
        o_valid_q <= 1'b0;
        o_last_q  <= 1'b0;
      end else begin
        cha_cnt  <= cnt_nxt;
        o_data_q <= word_nxt;
        o_last_q <= (cnt_nxt == LAST);
      end
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_data  = o_data_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_last  = o_last_q;
endmodule
